// File: rtl/vsub_pkg.sv
// Shared definitions for the byte-lane vector subtract arbiter.
//
// Contents:
//   LaneW        - width of one byte lane (8)
//   out_state_e  - output register occupancy (StEmpty / StFull)
//   req_id_t     - requester index (0 or 1)
//   other_req()  - the requester that is not the given one
//
// Optional feature macro used by the files that import this package: VSUB_SAT_EN.
package vsub_pkg;

    localparam int unsigned LaneW = 8;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_e;

    typedef logic req_id_t;

    localparam req_id_t ReqId0 = 1'b0;
    localparam req_id_t ReqId1 = 1'b1;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/vsub_lane.sv
// One byte lane of the vector subtractor: diff = a - b modulo 256.
// With sat set, a lane that borrows is clamped to 0x00 instead of wrapping.
//
// Ports:
//   a, b    in   LaneW  minuend / subtrahend
//   sat     in   1      clamp-on-borrow select
//   diff    out  LaneW  lane result
//   borrow  out  1      a < b (raised whether or not the lane is clamped)
module vsub_lane
    import vsub_pkg::*;
(
    input  logic [LaneW-1:0] a,
    input  logic [LaneW-1:0] b,
    input  logic             sat,
    output logic [LaneW-1:0] diff,
    output logic             borrow
);

    // One extra bit catches the borrow out of the lane.
    logic [LaneW:0] wide;

    assign wide   = {1'b0, a} - {1'b0, b};
    assign borrow = wide[LaneW];
    assign diff   = (sat && borrow) ? '0 : wide[LaneW-1:0];

endmodule

// File: rtl/vsub_arbiter.sv
// Two-requester round-robin arbiter feeding a byte-lane vector subtractor with a
// single-entry output register (one-cycle latency, full throughput).
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   reqN_valid / reqN_ready  requester N handshake (N = 0, 1)
//   reqN_vra / reqN_vrb      requester N minuend / subtrahend, VW bits
//   reqN_sat                 requester N saturate select (VSUB_SAT_EN only)
//   res_valid / res_ready    result handshake
//   res_vrt                  byte-wise difference vra - vrb
//   res_id                   requester that produced res_vrt
//   res_sat                  some lane clamped (VSUB_SAT_EN only)
//
// Build option: define VSUB_SAT_EN to add the saturate-on-borrow mode and its
// ports. Without it every operation wraps modulo 256 per lane.
module vsub_arbiter
    import vsub_pkg::*;
#(
    parameter int unsigned VW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [VW-1:0] req0_vra,
    input  logic [VW-1:0] req0_vrb,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [VW-1:0] req1_vra,
    input  logic [VW-1:0] req1_vrb,

`ifdef VSUB_SAT_EN
    input  logic          req0_sat,
    input  logic          req1_sat,
    output logic          res_sat,
`endif

    output logic          res_valid,
    input  logic          res_ready,
    output logic [VW-1:0] res_vrt,
    output logic          res_id
);

    localparam int unsigned NumLanes = VW / LaneW;

    out_state_e state_q, state_d;
    req_id_t    ptr_q, ptr_d;
    logic [VW-1:0] vrt_q, vrt_d;
    req_id_t    id_q, id_d;

    logic    can_accept;
    logic    fire0, fire1;
    logic    accept;
    req_id_t grant_id;

    logic [VW-1:0] sel_vra, sel_vrb;
    logic          sel_sat;
    logic          sat0, sat1;

    logic [VW-1:0]       lane_diff;
    logic [NumLanes-1:0] lane_borrow;

`ifdef VSUB_SAT_EN
    logic sat_q, sat_d;

    assign sat0 = req0_sat;
    assign sat1 = req1_sat;
`else
    assign sat0 = 1'b0;
    assign sat1 = 1'b0;

    // Borrow flags only matter for the saturate mode.
    logic unused_borrow;
    assign unused_borrow = ^lane_borrow;
`endif

    // Grant and ready generation. A requester's ready looks only at the other
    // requester's valid, never its own, so the pair cannot both fire: with the
    // pointer on N, the other side is ready only while N is not valid.
    always_comb begin
        can_accept = !rst && ((state_q == StEmpty) || res_ready);
        req0_ready = can_accept && ((ptr_q == ReqId0) || !req1_valid);
        req1_ready = can_accept && ((ptr_q == ReqId1) || !req0_valid);
        fire0      = req0_valid && req0_ready;
        fire1      = req1_valid && req1_ready;
        accept     = fire0 || fire1;
        grant_id   = fire1 ? ReqId1 : ReqId0;
    end

    // Operand select for the granted requester.
    always_comb begin
        if (grant_id == ReqId1) begin
            sel_vra = req1_vra;
            sel_vrb = req1_vrb;
            sel_sat = sat1;
        end else begin
            sel_vra = req0_vra;
            sel_vrb = req0_vrb;
            sel_sat = sat0;
        end
    end

    for (genvar i = 0; i < NumLanes; i++) begin : g_lane
        vsub_lane u_lane (
            .a      (sel_vra[i*LaneW +: LaneW]),
            .b      (sel_vrb[i*LaneW +: LaneW]),
            .sat    (sel_sat),
            .diff   (lane_diff[i*LaneW +: LaneW]),
            .borrow (lane_borrow[i])
        );
    end

    // Output stage next state. An accept always leaves the stage FULL (it either
    // fills an empty stage or replaces the result being drained this cycle).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        vrt_d   = vrt_q;
        id_d    = id_q;
`ifdef VSUB_SAT_EN
        sat_d   = sat_q;
`endif
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (!accept && res_ready) begin
                    state_d = StEmpty;
                end
            end
        endcase

        if (accept) begin
            ptr_d = other_req(grant_id);
            vrt_d = lane_diff;
            id_d  = grant_id;
`ifdef VSUB_SAT_EN
            sat_d = sel_sat && (|lane_borrow);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            ptr_q   <= ReqId0;
            vrt_q   <= '0;
            id_q    <= ReqId0;
`ifdef VSUB_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vrt_q   <= vrt_d;
            id_q    <= id_d;
`ifdef VSUB_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign res_valid = (state_q == StFull);
    assign res_vrt   = vrt_q;
    assign res_id    = id_q;
`ifdef VSUB_SAT_EN
    assign res_sat   = sat_q;
`endif

endmodule

// File: doc/vsub_arbiter.md
VSUB_ARBITER -- requirements
Module: vsub_arbiter

Interface
REQ-001 Parameter VW, default 32, vector width in bits; SHALL be a multiple of 8 (VW/8 byte lanes).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 offers an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready.
REQ-006 req0_vra, req0_vrb  input  VW each  requester 0 minuend / subtrahend.
REQ-007 req1_valid, req1_ready, req1_vra, req1_vrb: same as REQ-004..006 for requester 1.
REQ-008 req0_sat, req1_sat  input  1 each  saturate-mode select; present only when VSUB_SAT_EN is defined.
REQ-009 res_valid  output  1  result register holds a valid result.
REQ-010 res_ready  input  1  consumer accepts the result when res_valid&res_ready.
REQ-011 res_vrt  output  VW  byte-wise difference vra-vrb.
REQ-012 res_id  output  1  index of the requester that produced res_vrt.
REQ-013 res_sat  output  1  some lane clamped; present only when VSUB_SAT_EN is defined.

Function
REQ-014 Each byte lane i SHALL compute vra[8i+7:8i] - vrb[8i+7:8i] modulo 256, with no carry between lanes.
REQ-015 Output stage state SHALL be EMPTY or FULL; EMPTY->FULL on accept, FULL->EMPTY on drain without accept, FULL->FULL on drain with simultaneous accept or on stall.
REQ-016 Stage SHALL be able to accept when EMPTY, or FULL with res_ready=1 in the same cycle (full throughput, no bubble).
REQ-017 Only one requester SHALL be granted per cycle; reqN_ready=1 only for the granted requester while able to accept; the non-granted ready SHALL be 0.
REQ-018 Arbitration SHALL be round-robin: priority pointer initialised to requester 0; after each accepted transfer, the pointer moves to the other requester.
REQ-019 A single valid requester SHALL be granted regardless of the pointer.
REQ-020 Latency SHALL be exactly 1 cycle: a request accepted at edge k produces res_valid=1 with its result after edge k.
REQ-021 While FULL and res_ready=0, res_vrt, res_id and res_sat SHALL hold stable, and both reqN_ready SHALL be 0.
REQ-022 reqN_ready SHALL NOT depend on reqN_valid of the same requester; it MAY depend on the other requester's valid and on res_ready.
REQ-023 A requester deasserting valid before acceptance SHALL NOT change the pointer.

Reset
REQ-024 When rst=1 at a rising edge: state EMPTY, pointer=0, res_valid=0, res_vrt=0, res_id=0, res_sat=0.
REQ-025 During a rst=1 cycle, req0_ready and req1_ready SHALL be 0; a result pending at reset SHALL be discarded.

Configuration
REQ-026 Macro VSUB_SAT_EN: when defined, a request with sat=1 SHALL clamp each lane to 0x00 on borrow, and res_sat SHALL be 1 if any lane clamped; sat=0 behaves as REQ-014.
REQ-027 When VSUB_SAT_EN is undefined, the sat and res_sat ports SHALL be absent and all operations SHALL be modulo.

Structure
REQ-028 Package vsub_pkg SHALL hold the lane width constant (8), the output-state enum (EMPTY, FULL) and the requester-id typedef.
REQ-029 One sub-module, vsub_lane (8-bit subtract, optional clamp, borrow flag out), SHALL be instantiated VW/8 times.

Verification
REQ-030 Req0 only, vra=0x10203040, vrb=0x01020304, res_ready=1 -> next cycle res_valid=1, res_vrt=0x0F1E2D3C, res_id=0.
REQ-031 Modulo wrap: vra=0x00000000, vrb=0x01010101 -> res_vrt=0xFFFFFFFF; with VSUB_SAT_EN and sat=1 -> 0x00000000, res_sat=1.
REQ-032 Both requesters valid for 4 cycles, res_ready=1 -> res_id sequence 0,1,0,1 with one result per cycle.
REQ-033 Stall: FULL with res_ready=0 for 3 cycles and both requesters valid -> res_vrt stable, both ready=0; on release, the next grant follows the pointer.
REQ-034 rst asserted while FULL and req1 valid -> next cycle res_valid=0, pointer=0, the subsequent first grant goes to req0 when both are valid.
